// File: rtl/alu_host_framer.sv
// Host-side ALU packet framer: header from registered state, payload passed through with zero latency.
// m_axis_tready low stalls header and payload alike; response capture never backpressures.
module alu_host_framer #(
  parameter logic [7:0]  EchoOp        = 8'hEC,
  parameter int unsigned RspLen        = 4,
  parameter logic [31:0] TimeoutCycles = 32'd100000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [15:0] cmd_len_i,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  input  logic [7:0]  rsp_tdata_i,
  input  logic        rsp_tvalid_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_valid_o,
  output logic        rsp_timeout_o,
  output logic        cmd_err_o,
  output logic        busy_o
);

  localparam logic [15:0] RspLen16 = 16'(RspLen);

  typedef enum logic [2:0] {IDLE, HDR, PAY, WAIT_RSP, DONE} state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] len;
    logic [15:0] exp_cnt;
  } cmd_t;

  state_t      state;
  cmd_t        cmd_q;
  logic [1:0]  hdr_idx;
  logic [15:0] pay_cnt;
  logic [15:0] rx_cnt;
  logic [31:0] tmo_cnt;
  logic [15:0] total_len;
  logic [7:0]  hdr_dat;
  logic        cmd_acc;
  logic        m_hs;
  logic        rx_arm;
  logic        rsp_take;

  assign cmd_ready_o     = (state == IDLE);
  assign busy_o          = (state != IDLE);
  assign cmd_acc         = cmd_valid_i && cmd_ready_o;
  assign total_len       = cmd_q.len + 16'd4;
  assign s_axis_tready_o = (state == PAY) && m_axis_tready_i;
  assign m_hs            = m_axis_tvalid_o && m_axis_tready_i;
  assign rx_arm          = (state == HDR) || (state == PAY) || (state == WAIT_RSP);
  // Response bytes past the expected count are dropped, leaving the captured word intact.
  assign rsp_take        = rx_arm && rsp_tvalid_i && (rx_cnt != cmd_q.exp_cnt);

  always_comb begin
    hdr_dat = 8'h00;
    case (hdr_idx)
      2'd0:    hdr_dat = cmd_q.opcode;
      2'd2:    hdr_dat = total_len[7:0];
      2'd3:    hdr_dat = total_len[15:8];
      default: hdr_dat = 8'h00;
    endcase
  end

  always_comb begin
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = 8'h00;
    case (state)
      HDR: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = hdr_dat;
      end
      PAY: begin
        m_axis_tvalid_o = s_axis_tvalid_i;
        m_axis_tdata_o  = s_axis_tdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state         <= IDLE;
      cmd_q         <= '0;
      hdr_idx       <= '0;
      pay_cnt       <= '0;
      rx_cnt        <= '0;
      tmo_cnt       <= '0;
      rsp_data_o    <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      cmd_err_o     <= 1'b0;
    end else begin
      rsp_valid_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
      cmd_err_o     <= 1'b0;

      if (rsp_take) begin
        rsp_data_o <= {rsp_tdata_i, rsp_data_o[31:8]};
        rx_cnt     <= rx_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (cmd_acc) begin
            rsp_data_o <= '0;
            rx_cnt     <= '0;
            tmo_cnt    <= '0;
            hdr_idx    <= '0;
            // Oversize lengths would overflow total_len; reject without framing anything.
            if (cmd_len_i > 16'hFFFB) begin
              cmd_err_o <= 1'b1;
            end else begin
              cmd_q.opcode  <= cmd_opcode_i;
              cmd_q.len     <= cmd_len_i;
              cmd_q.exp_cnt <= (cmd_opcode_i == EchoOp) ? cmd_len_i : RspLen16;
              pay_cnt       <= cmd_len_i;
              state         <= HDR;
            end
          end
        end
        HDR: begin
          if (m_hs) begin
            hdr_idx <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              tmo_cnt <= '0;
              state   <= (cmd_q.len != 16'd0) ? PAY : WAIT_RSP;
            end
          end
        end
        PAY: begin
          if (m_hs) begin
            pay_cnt <= pay_cnt - 16'd1;
            if (pay_cnt == 16'd1) begin
              tmo_cnt <= '0;
              state   <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          // Completion is checked first so it always beats a coincident timeout.
          if (rx_cnt == cmd_q.exp_cnt) begin
            rsp_valid_o <= 1'b1;
            state       <= DONE;
          end else if (rsp_tvalid_i) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt >= TimeoutCycles - 32'd1) begin
            rsp_timeout_o <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_host_framer.sv
// Directed and randomized checks of alu_host_framer against a frame/response model.
`timescale 1ns/1ps
module tb_alu_host_framer;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_opcode_i;
  logic [15:0] cmd_len_i;
  logic [7:0]  s_axis_tdata_i;
  logic        s_axis_tvalid_i;
  logic        s_axis_tready_o;
  logic [7:0]  m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i;
  logic [7:0]  rsp_tdata_i = 8'h00;
  logic        rsp_tvalid_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_valid_o;
  logic        rsp_timeout_o;
  logic        cmd_err_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  alu_host_framer #(
    .EchoOp(8'hEC), .RspLen(4), .TimeoutCycles(32'd100)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_len_i(cmd_len_i),
    .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i),
    .s_axis_tready_o(s_axis_tready_o),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
    .m_axis_tready_i(m_axis_tready_i),
    .rsp_tdata_i(rsp_tdata_i), .rsp_tvalid_i(rsp_tvalid_i),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o),
    .rsp_timeout_o(rsp_timeout_o), .cmd_err_o(cmd_err_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] m_q[$];
  logic [7:0] stall_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] rsp_q[$];
  logic [7:0] rsp_list[$];
  int rv_cnt = 0, tmo_cnt = 0, ce_cnt = 0, stab_viol = 0, srdy_viol = 0;
  int last_hs = 0, tmo_cyc = 0;
  logic [31:0] rv_data = '0;
  logic busy_after_tmo = 1'b1;
  logic rsp_go = 1'b0;
  logic prev_stall = 1'b0, prev_tmo = 1'b0;
  logic [7:0] prev_dat = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder: feeds queued response bytes with random gaps.
  always @(posedge clk_i) begin
    #2;
    if (rsp_go && rsp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      rsp_tvalid_i = 1'b1;
      rsp_tdata_i  = rsp_q.pop_front();
    end else begin
      rsp_tvalid_i = 1'b0;
      rsp_tdata_i  = 8'($urandom);
    end
  end

  always @(negedge clk_i) begin
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      m_q.push_back(m_axis_tdata_o);
      last_hs = cyc + 1;
    end
    if (m_axis_tvalid_o && !m_axis_tready_i) stall_q.push_back(m_axis_tdata_o);
    if (prev_stall && (!m_axis_tvalid_o || m_axis_tdata_o !== prev_dat)) stab_viol++;
    prev_stall = m_axis_tvalid_o && !m_axis_tready_i;
    prev_dat   = m_axis_tdata_o;
    if (s_axis_tready_o && !m_axis_tready_i) srdy_viol++;
    if (rsp_valid_o) begin
      rv_cnt++;
      rv_data = rsp_data_o;
    end
    if (prev_tmo) busy_after_tmo = busy_o;
    if (rsp_timeout_o) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    prev_tmo = rsp_timeout_o;
    if (cmd_err_o) ce_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [7:0] op, input int len, input bit stall_hdr2,
                         input bit rand_rdy, input int abort_at);
    int  idx = 0;
    int  budget = 0;
    int  stall_left = 3;
    bit  hold = 1'b0;
    bit  aborted = 1'b0;
    m_q.delete(); stall_q.delete();
    rv_cnt = 0; tmo_cnt = 0; ce_cnt = 0; stab_viol = 0; srdy_viol = 0;
    busy_after_tmo = 1'b1;
    rsp_q = rsp_list;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_len_i = 16'(len);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    rsp_go = 1'b1;
    while (!aborted && (rv_cnt + tmo_cnt) == 0 && budget < 3000) begin
      if (abort_at >= 0 && m_q.size() == abort_at) begin
        reset_ni = 1'b0;
        s_axis_tvalid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mid_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        rsp_go = 1'b0;
        rsp_q.delete();
        aborted = 1'b1;
      end else begin
        if (stall_hdr2 && stall_left > 0 && m_q.size() == 2) begin
          m_axis_tready_i = 1'b0;
          stall_left--;
        end else if (rand_rdy) begin
          m_axis_tready_i = ($urandom_range(0, 3) != 0);
        end else begin
          m_axis_tready_i = 1'b1;
        end
        s_axis_tvalid_i = (idx < len) && (hold || $urandom_range(0, 2) != 0);
        s_axis_tdata_i  = (idx < len) ? pay_q[idx] : 8'($urandom);
        @(negedge clk_i);
        hold = s_axis_tvalid_i && !s_axis_tready_o;
        if (s_axis_tvalid_i && s_axis_tready_o) idx++;
        @(posedge clk_i); #1;
        budget++;
      end
    end
    s_axis_tvalid_i = 1'b0;
    m_axis_tready_i = 1'b1;
    budget = 0;
    while (rsp_q.size() > 0 && budget < 500) begin
      @(posedge clk_i); #1;
      budget++;
    end
    repeat (3) @(posedge clk_i);
    #1 rsp_go = 1'b0;
  endtask

  task automatic check_run(input logic [7:0] op, input int len, input bit exp_tmo, input string tag);
    logic [7:0]  fr[$];
    logic [15:0] tot;
    logic [31:0] word;
    int exp_n, k;
    tot = 16'(len + 4);
    fr = {op, 8'h00, tot[7:0], tot[15:8]};
    foreach (pay_q[i]) fr.push_back(pay_q[i]);
    chk({tag, "_frame_len"}, 32'(m_q.size()), 32'(fr.size()));
    for (int i = 0; i < fr.size() && i < m_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(m_q[i]), 32'(fr[i]));
    chk({tag, "_srdy_while_stalled"}, 32'(srdy_viol), 32'd0);
    chk({tag, "_stall_stability"}, 32'(stab_viol), 32'd0);
    if (exp_tmo) begin
      chk({tag, "_tmo_pulses"}, 32'(tmo_cnt), 32'd1);
      chk({tag, "_rsp_valid_pulses"}, 32'(rv_cnt), 32'd0);
      chk({tag, "_tmo_latency"}, 32'(tmo_cyc - last_hs), 32'd100);
      chk({tag, "_busy_after_tmo"}, 32'(busy_after_tmo), 32'd0);
    end else begin
      // Last min(exp,4) response bytes, newest in the top byte lane.
      exp_n = (op == 8'hEC) ? len : 4;
      k = (exp_n < 4) ? exp_n : 4;
      word = '0;
      for (int j = 0; j < k; j++) word[8*(3-j) +: 8] = rsp_list[exp_n-1-j];
      chk({tag, "_rsp_valid_pulses"}, 32'(rv_cnt), 32'd1);
      chk({tag, "_tmo_pulses"}, 32'(tmo_cnt), 32'd0);
      chk({tag, "_rsp_data"}, rv_data, word);
    end
  endtask

  initial begin
    logic [7:0] op;
    int len, exp_n, n, r;
    reset_ni = 1'b0; cmd_valid_i = 1'b0; cmd_opcode_i = '0; cmd_len_i = '0;
    s_axis_tvalid_i = 1'b0; s_axis_tdata_i = '0; m_axis_tready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_m_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_m_tdata", 32'(m_axis_tdata_o), 32'd0);
    @(posedge clk_i); #1 reset_ni = 1'b1;

    pay_q = {8'h48, 8'h69}; rsp_list = {8'h48, 8'h69};
    run_cmd(8'hEC, 2, 1'b0, 1'b0, -1);
    check_run(8'hEC, 2, 1'b0, "echo2");

    pay_q = {8'hFF, 8'h02, 8'h4B, 8'h0D, 8'h21, 8'h43, 8'h65, 8'h87};
    rsp_list = {8'h20, 8'h46, 8'hB0, 8'h94};
    run_cmd(8'hAD, 8, 1'b0, 1'b0, -1);
    check_run(8'hAD, 8, 1'b0, "add8");

    pay_q = {8'h5A, 8'hC3}; rsp_list = {8'h5A, 8'hC3};
    run_cmd(8'hEC, 2, 1'b1, 1'b0, -1);
    check_run(8'hEC, 2, 1'b0, "stall");
    chk("stall_cycles", 32'(stall_q.size()), 32'd3);
    foreach (stall_q[i]) chk($sformatf("stall_hold%0d", i), 32'(stall_q[i]), 32'h06);

    pay_q = {8'h11, 8'h22}; rsp_list.delete();
    run_cmd(8'hAD, 2, 1'b0, 1'b0, -1);
    check_run(8'hAD, 2, 1'b1, "timeout");

    pay_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}; rsp_list.delete();
    run_cmd(8'hAD, 8, 1'b0, 1'b0, 7);
    pay_q = {8'hA1, 8'hB2, 8'hC3}; rsp_list = {8'hA1, 8'hB2, 8'hC3};
    run_cmd(8'hEC, 3, 1'b0, 1'b0, -1);
    check_run(8'hEC, 3, 1'b0, "post_rst");

    m_q.delete(); ce_cnt = 0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_opcode_i = 8'hAD; cmd_len_i = 16'hFFFC;
    @(posedge clk_i); #1 cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("oversize_err", 32'(cmd_err_o), 32'd1);
    chk("oversize_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("oversize_err_once", 32'(cmd_err_o), 32'd0);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_len_i = 16'hFFFF;
    @(posedge clk_i); #1 cmd_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("oversize_err_count", 32'(ce_cnt), 32'd2);
    chk("oversize_no_bytes", 32'(m_q.size()), 32'd0);

    pay_q.delete(); rsp_list.delete();
    run_cmd(8'hEC, 0, 1'b0, 1'b0, -1);
    check_run(8'hEC, 0, 1'b0, "echo0");

    for (int t = 0; t < 12; t++) begin
      r  = $urandom_range(0, 2);
      op = (r == 0) ? 8'hEC : (r == 1) ? 8'hAD : 8'($urandom);
      len = $urandom_range(0, 12);
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
      exp_n = (op == 8'hEC) ? len : 4;
      n = exp_n + $urandom_range(0, 2);
      rsp_list.delete();
      for (int i = 0; i < n; i++) rsp_list.push_back(8'($urandom));
      run_cmd(op, len, 1'b0, 1'b1, -1);
      check_run(op, len, 1'b0, $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_host_framer.md
Name: alu_host_framer

Overview:
Host-side initiator for the UART ALU packet protocol; the counterpart of the alu_wrap responder.
- Accepts a command (opcode + payload length) and a payload byte stream.
- Emits the framed packet as an AXI-stream byte stream toward a uart_tx instance.
- Collects the ALU's response bytes from a uart_rx instance and reports a 32-bit result, or a timeout.
- Used by on-chip self-test and as a synthesizable bench driver for alu_wrap.

Parameters:
EchoOp, 8'hEC, opcode whose expected response length equals the payload length.
RspLen, 4, expected response byte count for every non-echo opcode.
TimeoutCycles, 32'd100000, idle cycles allowed in WAIT_RSP before a timeout is declared; must be >= 1.

Ports:
clk_i  in  1  clock
reset_ni  in  1  synchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready; high only in IDLE
cmd_opcode_i  in  8  opcode byte
cmd_len_i  in  16  payload byte count, excluding the header
s_axis_tdata_i  in  8  payload byte
s_axis_tvalid_i  in  1  payload valid
s_axis_tready_o  out  1  payload ready; high only in PAY while m_axis_tready_i is high
m_axis_tdata_o  out  8  framed byte to uart_tx
m_axis_tvalid_o  out  1  framed byte valid
m_axis_tready_i  in  1  uart_tx ready
rsp_tdata_i  in  8  response byte from uart_rx
rsp_tvalid_i  in  1  response byte strobe (no backpressure)
rsp_data_o  out  32  assembled response word
rsp_valid_o  out  1  one-cycle pulse: response complete
rsp_timeout_o  out  1  one-cycle pulse: response timed out
cmd_err_o  out  1  one-cycle pulse: command rejected
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_i. reset_ni is synchronous and active-low.
- Reset values:
  - Outputs: m_axis_tvalid_o=0, s_axis_tready_o=0, rsp_valid_o=0, rsp_timeout_o=0, cmd_err_o=0, busy_o=0, cmd_ready_o=1 (IDLE), rsp_data_o=0, m_axis_tdata_o=0.
  - Internal counters clear to 0.
  - Reset mid-packet abandons the packet. No partial byte is held over.
- Frame format, all fields little-endian:
  - Byte 0: opcode.
  - Byte 1: 8'h00.
  - Byte 2: total_len[7:0].
  - Byte 3: total_len[15:8].
  - Then cmd_len_i payload bytes.
  - total_len = cmd_len_i + 4, so total_len counts the header.
- Command acceptance:
  - A command is accepted on cmd_valid_i && cmd_ready_o.
  - On acceptance, opcode, cmd_len_i and exp_cnt are latched.
  - exp_cnt = (opcode == EchoOp) ? cmd_len_i : RspLen.
  - If cmd_len_i > 16'hFFFB: cmd_err_o pulses the following cycle, the FSM stays in IDLE, and no bytes are emitted.
- FSM states: IDLE, HDR, PAY, WAIT_RSP, DONE.
  - IDLE -> HDR on a valid accept.
  - HDR:
    - m_axis_tvalid_o=1 and m_axis_tdata_o = header byte at hdr_idx.
    - hdr_idx advances only on a handshake.
    - After byte 3 is handshaked: go to PAY if cmd_len_i != 0, else go to WAIT_RSP.
  - PAY:
    - Pass-through with zero latency: m_axis_tdata_o = s_axis_tdata_i and m_axis_tvalid_o = s_axis_tvalid_i.
    - The payload counter decrements on each handshake.
    - After the last payload byte is handshaked -> WAIT_RSP.
  - WAIT_RSP:
    - Timeout counter counts cycles with no rsp byte; it clears on each rsp_tvalid_i.
    - When rx_cnt reaches exp_cnt -> DONE.
    - When the counter reaches TimeoutCycles: pulse rsp_timeout_o and go to IDLE.
  - DONE: pulse rsp_valid_o for one cycle, then go to IDLE.
- Backpressure:
  - While m_axis_tvalid_o is high and m_axis_tready_i is low, m_axis_tdata_o is held stable.
  - No byte is dropped or duplicated.
- Response capture:
  - Capture is armed from the cycle after command accept, in HDR, PAY and WAIT_RSP. The echo response may start before the payload finishes.
  - Each rsp_tvalid_i does two things: rsp_data_o <= {rsp_tdata_i, rsp_data_o[31:8]}, and rx_cnt increments, saturating at exp_cnt.
  - Bytes beyond exp_cnt are ignored.
  - Bytes received in IDLE are ignored.
  - rsp_data_o clears on command accept.
  - Net effect: after 4 bytes, rsp_data_o holds the little-endian word. For echo lengths other than 4, it holds the last <=4 bytes, MSB-aligned.
- Zero-response case: exp_cnt == 0 (echo with zero payload) goes WAIT_RSP -> DONE on the next cycle.
- Simultaneous events:
  - If the exp_cnt-th byte arrives in the same cycle the timeout would fire, completion wins: no rsp_timeout_o.
  - An exp_cnt reached during HDR or PAY goes WAIT_RSP -> DONE on the next cycle.

Test Plan:
1. Echo, opcode 8'hEC, cmd_len 2, payload 48 69, with a loopback responder returning 48 69 -> m_axis bytes EC 00 06 00 48 69 in order. rsp_valid_o pulses once; rsp_data_o = 32'h6948_0000.
2. Add, opcode 8'hAD, cmd_len 8, payload FF 02 4B 0D 21 43 65 87, with the responder returning 20 46 B0 94 -> header AD 00 0C 00. rsp_data_o = 32'h94B0_4620 on the rsp_valid_o pulse.
3. Drive m_axis_tready_i low for 3 cycles while header byte 2 is presented, and s_axis_tvalid_i gapped in PAY -> m_axis_tdata_o stays 8'h06 throughout the stall. The output sequence is unchanged with no skips or repeats. s_axis_tready_o is low while m_axis_tready_i is low.
4. Timeout: add command, no response, TimeoutCycles=100 -> rsp_timeout_o pulses exactly 100 cycles after WAIT_RSP entry. rsp_valid_o never pulses; busy_o is 0 the next cycle.
5. Reset mid-packet: reset_ni low for 2 cycles during PAY byte 3 -> m_axis_tvalid_o is 0 after the first reset edge and cmd_ready_o is 1. A following echo command is framed starting at its opcode byte.
6. Oversize: cmd_len_i = 16'hFFFC -> cmd_err_o pulses one cycle and m_axis_tvalid_o stays 0. Next, an echo with cmd_len 0 -> emits EC 00 04 00, then rsp_valid_o pulses with rsp_data_o = 0.
